// File: rtl/fifo_pkg.sv
// Shared constants for the asynchronous pixel FIFO read-side stages.
// Default word and counter widths, plus the depth of the FWFT output buffer.
package fifo_pkg;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 16;
    localparam int FWFT_DEPTH = 2;
    localparam int OCC_W      = $clog2(FWFT_DEPTH + 1);
endpackage

// File: rtl/fwft_skid2.sv
// Purpose: 2-entry head/tail word buffer with simultaneous push and pop, strict FIFO order.
// Latency: a push lands in head (if empty after pop) or tail on the next rclk edge.
// Backpressure: none internally; the caller must never push into a full buffer.
module fwft_skid2
    import fifo_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  push,
    input  logic [data_width-1:0] push_dat,
    input  logic                  pop,
    output logic [OCC_W-1:0]      occ,
    output logic [data_width-1:0] head
);

    logic [OCC_W-1:0]      occ_q, occ_d, occ_after_pop;
    logic [data_width-1:0] head_q, head_d;
    logic [data_width-1:0] tail_q, tail_d;

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;

        occ_after_pop = occ_q - OCC_W'(pop);

        if (pop && (occ_q == OCC_W'(FWFT_DEPTH))) begin
            head_d = tail_q;
        end

        // Push lands behind whatever is still held after this cycle's pop.
        if (push) begin
            if (occ_after_pop == '0) begin
                head_d = push_dat;
            end else begin
                tail_d = push_dat;
            end
        end

        occ_d = occ_after_pop + OCC_W'(push);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            occ_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    assign occ  = occ_q;
    assign head = head_q;

endmodule

// File: rtl/fifo_rd_fwft.sv
// Purpose: turn pop-style FIFO reads into a first-word-fall-through valid/ready stream; optional delivered-word counter under FIFO_RD_CNT_EN.
// Latency: rempty low in cycle T gives rinc in T, data in T+1, out_valid from T+2; one word/cycle sustained.
// Backpressure: rinc issued only while stored + in-flight words after this pop stay below 2; out_valid/out_data hold while out_ready is low.
module fifo_rd_fwft
    import fifo_pkg::*;
#(
    parameter int data_width = DATA_WIDTH
`ifdef FIFO_RD_CNT_EN
    ,
    parameter int cnt_width  = CNT_WIDTH
`endif
) (
    input  logic                  rclk,
    input  logic                  rrst_n,
    input  logic                  rempty,
    output logic                  rinc,
    input  logic [data_width-1:0] rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [data_width-1:0] out_data
`ifdef FIFO_RD_CNT_EN
    ,
    output logic [cnt_width-1:0]  out_count
`endif
);

    logic             inflight_q, inflight_d;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] level;
    logic             pop;

    assign out_valid = (occ != '0);
    assign pop       = out_valid & out_ready;

    // Credit check: words held or due after this cycle's pop must leave room for one more.
    // Gated by rrst_n so no pop is requested while the pointers are held in reset.
    always_comb begin
        level      = occ + OCC_W'(inflight_q) - OCC_W'(pop);
        rinc       = rrst_n & ~rempty & (level < OCC_W'(FWFT_DEPTH));
        inflight_d = rinc;
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    fwft_skid2 #(
        .data_width (data_width)
    ) u_buf (
        .rclk     (rclk),
        .rrst_n   (rrst_n),
        .push     (inflight_q),
        .push_dat (rd_data),
        .pop      (pop),
        .occ      (occ),
        .head     (out_data)
    );

`ifdef FIFO_RD_CNT_EN
    logic [cnt_width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + cnt_width'(pop);
    end

    always_ff @(posedge rclk or negedge rrst_n) begin
        if (!rrst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign out_count = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_rd_fwft.sv
// Self-checking bench for fifo_rd_fwft: upstream FIFO modelled as a word queue,
// expected output order kept as a queue of issued reads.
module tb_fifo_rd_fwft;

    localparam int DW = 16;
`ifdef FIFO_RD_CNT_EN
    localparam int CW = 4;
    logic [CW-1:0] out_count;
`endif

    logic          rclk = 1'b0;
    logic          rrst_n = 1'b0;
    logic          rempty = 1'b1;
    logic          rinc;
    logic [DW-1:0] rd_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;

    always #5 rclk = ~rclk;

    fifo_rd_fwft #(
        .data_width (DW)
`ifdef FIFO_RD_CNT_EN
        ,
        .cnt_width  (CW)
`endif
    ) dut (
        .rclk      (rclk),
        .rrst_n    (rrst_n),
        .rempty    (rempty),
        .rinc      (rinc),
        .rd_data   (rd_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef FIFO_RD_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] src_q[$];
    logic [DW-1:0] exp_q[$];
    int            delivered = 0;
    int            pushed = 0;
    logic          force_empty = 1'b0;
    logic          hold_q = 1'b0;
    logic [DW-1:0] hold_dat = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic upd_rempty();
        rempty = (src_q.size() == 0) || force_empty;
    endtask

    // One rclk cycle: observe pre-edge handshakes, then emulate the upstream memory.
    task automatic tick();
        logic          p_pop, p_rinc;
        logic [DW-1:0] p_dat, w;
        #1;
        if (hold_q) begin
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", 32'(out_data), 32'(hold_dat));
        end
        if (rinc) check("rinc_while_rempty", 32'(rempty), 32'd0);
        p_pop    = out_valid & out_ready;
        p_rinc   = rinc;
        p_dat    = out_data;
        hold_q   = out_valid & ~out_ready;
        hold_dat = out_data;
        if (p_pop) begin
            if (exp_q.size() == 0) begin
                check("pop_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
                check("pop_order", 32'(p_dat), 32'(exp_q[0]));
                void'(exp_q.pop_front());
                delivered++;
            end
        end
        @(posedge rclk);
        #1;
        if (p_rinc) begin
            w = (src_q.size() != 0) ? src_q.pop_front() : 16'($urandom);
            rd_data = w;
            exp_q.push_back(w);
        end else begin
            rd_data = 16'($urandom);
        end
        upd_rempty();
        check("outstanding_le2", 32'(exp_q.size() <= 2), 32'd1);
        #1;
    endtask

    // Holds rempty=0 during reset; upstream state (src_q) is left to the caller.
    task automatic do_reset();
        rrst_n = 1'b0;
        #1;
        exp_q.delete();
        delivered = 0;
        hold_q = 1'b0;
        force_empty = 1'b0;
        rempty = 1'b0;
        #1;
        check("rst_rinc", 32'(rinc), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
`ifdef FIFO_RD_CNT_EN
        check("rst_count", 32'(out_count), 32'd0);
`endif
        @(negedge rclk);
        rrst_n = 1'b1;
        upd_rempty();
        #1;
    endtask

    initial begin
        int d0, first_v, vcount, last_v;

        // Reset, then rinc on the first cycle after release
        src_q.push_back(16'h1111);
        do_reset();
        check("release_rinc", 32'(rinc), 32'd1);
        out_ready = 1'b1;
        repeat (4) tick();
        check("release_word_delivered", 32'(delivered), 32'd1);

        // Single word with hold
        out_ready = 1'b0;
        src_q.push_back(16'hA5A5);
        upd_rempty();
        #1;
        check("single_rinc", 32'(rinc), 32'd1);
        tick();
        check("single_valid_t1", 32'(out_valid), 32'd0);
        check("single_no_rinc", 32'(rinc), 32'd0);
        tick();
        check("single_valid_t2", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h0000A5A5);
        repeat (3) tick();
        out_ready = 1'b1;
        tick();
        check("single_valid_drop", 32'(out_valid), 32'd0);

        // Streaming 0..63
        d0 = delivered;
        for (int i = 0; i < 64; i++) src_q.push_back(16'(i));
        upd_rempty();
        first_v = -1; last_v = -1; vcount = 0;
        for (int i = 0; i < 70; i++) begin
            tick();
            if (out_valid) begin
                if (first_v < 0) first_v = i;
                last_v = i;
                vcount++;
            end
        end
        check("stream_first_valid", 32'(first_v), 32'd1);
        check("stream_valid_cycles", 32'(vcount), 32'd64);
        check("stream_no_gaps", 32'(last_v - first_v + 1), 32'd64);
        check("stream_delivered", 32'(delivered - d0), 32'd64);

        // Backpressure
        out_ready = 1'b0;
        d0 = delivered;
        for (int i = 0; i < 10; i++) src_q.push_back(16'(100 + i));
        upd_rempty();
        repeat (6) tick();
        check("bp_outstanding", 32'(exp_q.size()), 32'd2);
        check("bp_valid", 32'(out_valid), 32'd1);
        check("bp_head", 32'(out_data), 32'd100);
        check("bp_rinc", 32'(rinc), 32'd0);
        force_empty = 1'b1;
        upd_rempty();
        repeat (3) tick();
        force_empty = 1'b0;
        upd_rempty();
        out_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("bp_delivered", 32'(delivered - d0), 32'd10);

        // Empty boundary: rempty rises right after the only rinc
        d0 = delivered;
        src_q.push_back(16'd200);
        upd_rempty();
        tick();
        check("eb_rinc_off", 32'(rinc), 32'd0);
        check("eb_valid_t1", 32'(out_valid), 32'd0);
        tick();
        check("eb_valid_t2", 32'(out_valid), 32'd1);
        check("eb_data", 32'(out_data), 32'd200);
        tick();
        check("eb_valid_drop", 32'(out_valid), 32'd0);
        repeat (3) tick();
        check("eb_idle_rinc", 32'(rinc), 32'd0);
        check("eb_delivered", 32'(delivered - d0), 32'd1);

        // Randomized traffic with random consumer stalls and upstream empty windows
        d0 = delivered;
        pushed = 0;
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) begin
                src_q.push_back(16'($urandom));
                pushed++;
            end
            force_empty = ($urandom_range(0, 7) == 0);
            upd_rempty();
            tick();
        end
        force_empty = 1'b0;
        out_ready = 1'b1;
        upd_rempty();
        for (int i = 0; i < 600; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("rand_drained", 32'(src_q.size() + exp_q.size()), 32'd0);
        check("rand_delivered", 32'(delivered - d0), 32'(pushed));
`ifdef FIFO_RD_CNT_EN
        check("rand_count", 32'(out_count), 32'(delivered % (1 << CW)));
`endif

        // Counter wrap and reset mid-stream
        do_reset();
        for (int i = 0; i < 17; i++) src_q.push_back(16'(300 + i));
        upd_rempty();
        for (int i = 0; i < 40; i++) begin
            if (src_q.size() == 0 && exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("cnt_delivered", 32'(delivered), 32'd17);
`ifdef FIFO_RD_CNT_EN
        check("cnt_wrap", 32'(out_count), 32'(17 % (1 << CW)));
`endif
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) src_q.push_back(16'(500 + i));
        upd_rempty();
        tick();
        tick();
        check("mid_outstanding", 32'(exp_q.size()), 32'd2);
        check("mid_valid", 32'(out_valid), 32'd1);
        src_q.delete();
        do_reset();
        out_ready = 1'b1;
        repeat (4) tick();
        check("post_rst_valid", 32'(out_valid), 32'd0);
        check("post_rst_delivered", 32'(delivered), 32'd0);
`ifdef FIFO_RD_CNT_EN
        check("post_rst_count", 32'(out_count), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

endmodule

// File: doc/fifo_rd_fwft.md
# fifo_rd_fwft

Read-domain output stage of the asynchronous pixel FIFO. Sits directly downstream of the read-pointer/empty logic and the dual-port memory. It turns the pop-style interface (rempty, rinc, registered memory read data) into a first-word-fall-through valid/ready stream for readout consumers in the rclk domain. A 2-entry buffer sustains one word per cycle.

## Interface
- data_width, 16, width of a FIFO word (one CCD pixel sample)
- cnt_width, 16, width of the delivered-word counter (FIFO_RD_CNT_EN only)

- rclk  in  1  read-domain clock
- rrst_n  in  1  reset, asynchronous, active-low; clock rclk
- rempty  in  1  FIFO empty flag from the read-pointer logic, registered in rclk
- rinc  out  1  pop request to the read-pointer logic; never high while rempty=1
- rd_data  in  data_width  memory read data; valid the cycle after the edge that sampled rinc=1
- out_valid  out  1  out_data holds a word
- out_ready  in  1  consumer accepts the word when out_valid & out_ready
- out_data  out  data_width  head word of the buffer
- out_count  out  cnt_width  words delivered since reset (FIFO_RD_CNT_EN only)

## Operation
- State: occ (0..2, words held), inflight (1 bit, read issued and data due next cycle), 2-entry buffer (head, tail).
- pop = out_valid & out_ready.
- rinc = ~rempty & ((occ + inflight - pop) < 2). This is combinational from rempty, out_ready and registered state. Buffer space always covers every issued read.
- inflight_next = rinc.
- If inflight=1, rd_data is written into the buffer: into head when the buffer is empty after the pop, otherwise into tail.
- Pop with occ=2: tail moves to head.
- Push and pop in the same cycle: occ unchanged, and ordering is preserved (FIFO order strictly).
- out_valid = (occ != 0).
- out_data = head. It is registered and is only updated on push-to-empty or pop.
- Holding out_ready=0: out_data and out_valid stay stable (standard valid/ready, no retraction).
- Arithmetic: occ + inflight is evaluated in 2 bits, and the pop subtraction never underflows because pop implies occ≥1.

## Timing
- Reset (rrst_n low, async): occ=0, inflight=0, out_valid=0, out_data=0, rinc=0 (rempty is 1 from upstream), out_count=0.
- Reset asserted mid-transfer discards buffered and in-flight words. Upstream pointers reset at the same time, so nothing is lost relative to the pointers.
- Latency: rempty falls during cycle T → rinc=1 in T → rd_data valid in T+1 → out_valid=1 from T+2.
- Throughput: 1 word/cycle while rempty=0 and out_ready=1.
- Backpressure: at most 2 reads are outstanding plus stored. With out_ready=0 and 2 words stored, rinc stays 0.
- rempty asserting stops new rinc the same cycle. An in-flight word is still captured and delivered.

## Configuration
- FIFO_RD_CNT_EN defined:
  - out_count increments by 1 on each pop and wraps modulo 2^cnt_width.
  - The readout sequencer uses it to check line lengths.
- Undefined: the out_count port and the counter register are absent. All other behaviour is identical.

## Structure
- Shared package fifo_pkg:
  - default data_width (16), default cnt_width (16)
  - buffer depth constant FWFT_DEPTH=2
- Sub-module fwft_skid2:
  - the 2-entry buffer with occ, push/pop and head/tail moves
  - fifo_rd_fwft holds the rinc/inflight credit logic, the optional counter and the instance.

## Test plan
- Reset: rrst_n low with rempty=0 → rinc=0, out_valid=0, out_count=0. Release → rinc=1 in the first cycle.
- Single word: rempty low for one pop, rd_data=16'hA5A5 → out_valid=1 two cycles after rinc, out_data=16'hA5A5. Hold out_ready=0 → stable. Ready → out_valid=0 the next cycle.
- Streaming: 64 words 0..63 with out_ready=1 → one word/cycle after 2-cycle latency, in order, no gaps.
- Backpressure: out_ready=0 with the FIFO non-empty → exactly 2 words buffered, rinc=0 thereafter, no rinc while rempty=1. Release → words delivered in order.
- Empty boundary: rempty rises the cycle after rinc → in-flight word delivered, no further rinc, out_valid drops after the last pop.
- Counter (FIFO_RD_CNT_EN, cnt_width=4): 17 pops → out_count=1 (wrap). Reset mid-stream with 1 word stored and 1 in flight → out_count=0, out_valid=0, no stale word after release.
